// File: rtl/rtl_dp_pkg.sv
// Shared types and helpers for the rtl_datapath slice: op codes, sequencer states,
// the latched command record and immediate sign extension.
package rtl_dp_pkg;

  localparam int unsigned CMD_REG_W = 5;
  localparam int unsigned CMD_IMM_W = 64;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5,
    OP_LD  = 3'd6,
    OP_ST  = 3'd7
  } opCode_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_MEM  = 3'd4,
    S_T5   = 3'd5
  } dpState_t;

  // Fields are sized for the largest legal configuration; the top slices them down.
  typedef struct packed {
    opCode_t                opCode;
    logic [CMD_REG_W-1:0]   ra;
    logic [CMD_REG_W-1:0]   rb;
    logic [CMD_REG_W-1:0]   rc;
    logic                   useImm;
    logic [CMD_IMM_W-1:0]   imm;
  } cmd_t;

  function automatic logic [CMD_IMM_W-1:0] signExtend(input logic [CMD_IMM_W-1:0] imm,
                                                      input int unsigned immW);
    int unsigned sh;
    sh = CMD_IMM_W - immW;
    return CMD_IMM_W'($signed(imm << sh) >>> sh);
  endfunction

  function automatic logic isMemOp(input opCode_t op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/rtl_datapath_if.sv
// Op handshake, memory port and debug port of rtl_datapath.
// slave = the datapath side, master = the control unit / memory / debug side.
interface rtl_datapath_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IMM_W    = 19
);
  localparam int REG_W = $clog2(NUM_REGS);

  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_code;
  logic [REG_W-1:0]  op_ra;
  logic [REG_W-1:0]  op_rb;
  logic [REG_W-1:0]  op_rc;
  logic              op_use_imm;
  logic [IMM_W-1:0]  op_imm;
  logic              done;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [DATA_W-1:0] bus_out;
  logic [REG_W-1:0]  dbg_sel;
  logic [DATA_W-1:0] dbg_data;

  modport slave (
    input  op_valid, op_code, op_ra, op_rb, op_rc, op_use_imm, op_imm,
           mem_rdata, mem_ack, dbg_sel,
    output op_ready, done, mem_addr, mem_wdata, mem_rd, mem_wr, bus_out, dbg_data
  );

  modport master (
    output op_valid, op_code, op_ra, op_rb, op_rc, op_use_imm, op_imm,
           mem_rdata, mem_ack, dbg_sel,
    input  op_ready, done, mem_addr, mem_wdata, mem_rd, mem_wr, bus_out, dbg_data
  );

endinterface

// File: rtl/rtl_dp_alu.sv
// Combinational ALU for rtl_datapath: Z = op(Y, bus), modulo 2^DATA_W.
// Shift amounts use only the low $clog2(DATA_W) bits of the bus.
module rtl_dp_alu import rtl_dp_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  opCode_t           op,
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] z
);
  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shAmt;
  assign shAmt = bus[SH_W-1:0];

  always_comb begin
    z = '0;
    case (op)
      OP_ADD, OP_LD, OP_ST: z = y + bus;
      OP_SUB:               z = y - bus;
      OP_AND:               z = y & bus;
      OP_OR:                z = y | bus;
      OP_SHL:               z = y << shAmt;
      OP_SHR:               z = y >> shAmt;
    endcase
  end

endmodule

// File: rtl/rtl_datapath.sv
// Self-sequencing single-bus datapath: register file, Y/Z/MAR/MDR, bus mux and T-state sequencer.
// Optional macro RTL_DP_R0_ZERO_EN makes R0 a hard-wired zero register.
//
// state | meaning
// IDLE  | op_ready high, latch command on op_valid
// T1    | bus <- R[rb], Y <- bus
// T2    | bus <- R[rc] / ext imm, Z <- ALU(Y, bus)
// T3    | ALU op: R[ra] <- Z; LD/ST: MAR <- Z (ST: MDR <- R[ra])
// MEM   | strobe held until mem_ack
// T5    | LD writeback: R[ra] <- MDR
module rtl_datapath import rtl_dp_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int IMM_W    = 19
) (
  input logic           clk,
  input logic           clr,
  rtl_datapath_if.slave dp
);
  localparam int REG_W = $clog2(NUM_REGS);

  dpState_t          state;
  cmd_t              cmd;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] yReg, zReg, marReg, mdrReg;
  logic              readyReg, doneReg, rdReg, wrReg;

  logic [DATA_W-1:0] bus, aluZ, immExt;
  logic [DATA_W-1:0] raVal, rbVal, rcVal, dbgVal;
  logic [REG_W-1:0]  raIdx, rbIdx, rcIdx;
  logic              memOp, raWritable;
  opCode_t           aluOp;
  logic              cmdUnused;

  assign raIdx     = cmd.ra[REG_W-1:0];
  assign rbIdx     = cmd.rb[REG_W-1:0];
  assign rcIdx     = cmd.rc[REG_W-1:0];
  assign memOp     = isMemOp(cmd.opCode);
  assign immExt    = DATA_W'(signExtend(cmd.imm, IMM_W));
  assign aluOp     = memOp ? OP_ADD : cmd.opCode;
  assign cmdUnused = ^cmd;

  function automatic logic [DATA_W-1:0] readReg(input logic [REG_W-1:0] idx);
`ifdef RTL_DP_R0_ZERO_EN
    if (idx == '0) return '0;
`endif
    return regs[idx];
  endfunction

  always_comb begin
    raVal  = readReg(raIdx);
    rbVal  = readReg(rbIdx);
    rcVal  = readReg(rcIdx);
    dbgVal = readReg(dp.dbg_sel);
  end

  always_comb begin
    raWritable = 1'b1;
`ifdef RTL_DP_R0_ZERO_EN
    raWritable = (raIdx != '0);
`endif
  end

  always_comb begin
    bus = '0;
    case (state)
      S_T1:    bus = rbVal;
      S_T2:    bus = (cmd.useImm || memOp) ? immExt : rcVal;
      S_T3:    bus = zReg;
      S_T5:    bus = mdrReg;
      default: bus = '0;
    endcase
  end

  rtl_dp_alu #(.DATA_W(DATA_W)) uAlu (
    .op  (aluOp),
    .y   (yReg),
    .bus (bus),
    .z   (aluZ)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_IDLE;
      cmd      <= '0;
      yReg     <= '0;
      zReg     <= '0;
      marReg   <= '0;
      mdrReg   <= '0;
      readyReg <= 1'b1;
      doneReg  <= 1'b0;
      rdReg    <= 1'b0;
      wrReg    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dp.op_valid) begin
            cmd.opCode <= opCode_t'(dp.op_code);
            cmd.ra     <= CMD_REG_W'(dp.op_ra);
            cmd.rb     <= CMD_REG_W'(dp.op_rb);
            cmd.rc     <= CMD_REG_W'(dp.op_rc);
            cmd.useImm <= dp.op_use_imm;
            cmd.imm    <= CMD_IMM_W'(dp.op_imm);
            readyReg   <= 1'b0;
            state      <= S_T1;
          end
        end
        S_T1: begin
          yReg  <= bus;
          state <= S_T2;
        end
        S_T2: begin
          zReg  <= aluZ;
          state <= S_T3;
        end
        S_T3: begin
          if (memOp) begin
            marReg <= bus;
            if (cmd.opCode == OP_ST) mdrReg <= raVal;
            rdReg  <= (cmd.opCode == OP_LD);
            wrReg  <= (cmd.opCode == OP_ST);
            state  <= S_MEM;
          end else begin
            if (raWritable) regs[raIdx] <= bus;
            doneReg  <= 1'b1;
            readyReg <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_MEM: begin
          if (dp.mem_ack) begin
            rdReg <= 1'b0;
            wrReg <= 1'b0;
            if (cmd.opCode == OP_LD) begin
              mdrReg <= dp.mem_rdata;
              state  <= S_T5;
            end else begin
              doneReg  <= 1'b1;
              readyReg <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end
        S_T5: begin
          if (raWritable) regs[raIdx] <= bus;
          doneReg  <= 1'b1;
          readyReg <= 1'b1;
          state    <= S_IDLE;
        end
        default: begin
          readyReg <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

  assign dp.op_ready  = readyReg;
  assign dp.done      = doneReg;
  assign dp.mem_rd    = rdReg;
  assign dp.mem_wr    = wrReg;
  assign dp.mem_addr  = marReg;
  assign dp.mem_wdata = mdrReg;
  assign dp.bus_out   = bus;
  assign dp.dbg_data  = dbgVal;

endmodule

// File: tb/tb_rtl_datapath.sv
// Directed bench for rtl_datapath: table of ALU ops plus hand-written memory, back-to-back and reset sequences.
module tb_rtl_datapath;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int IMM_W    = 19;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  rtl_datapath_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IMM_W(IMM_W)) dpIf ();

  rtl_datapath #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IMM_W(IMM_W)) dut (
    .clk (clk),
    .clr (clr),
    .dp  (dpIf)
  );

  typedef struct {
    logic [2:0]        code;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [3:0]        rc;
    logic              useImm;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] expVal;
  } vec_t;

  vec_t              vecs [12];
  logic [DATA_W-1:0] model [NUM_REGS];
  int                nCompared = 0;
  int                nMismatch = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic offerOp(input logic [2:0] code, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rc, input logic useImm, input logic [IMM_W-1:0] imm,
                         output logic accepted);
    @(negedge clk);
    dpIf.op_code    = code;
    dpIf.op_ra      = ra;
    dpIf.op_rb      = rb;
    dpIf.op_rc      = rc;
    dpIf.op_use_imm = useImm;
    dpIf.op_imm     = imm;
    dpIf.op_valid   = 1'b1;
    for (int w = 0; w < 20 && !dpIf.op_ready; w++) @(negedge clk);
    accepted = dpIf.op_ready;
    if (!accepted) check("accept_timeout", 64'(dpIf.op_ready), 64'd1);
    @(negedge clk);
    dpIf.op_valid = 1'b0;
  endtask

  task automatic runAlu(input vec_t v, input int idx);
    logic acc;
    int   lat;
    offerOp(v.code, v.ra, v.rb, v.rc, v.useImm, v.imm, acc);
    if (!acc) return;
    check($sformatf("row%0d_t1_bus", idx), 64'(dpIf.bus_out), 64'(model[v.rb]));
    lat = 0;
    while (!dpIf.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("row%0d_done_lat", idx), 64'(lat), 64'd3);
    check($sformatf("row%0d_ready", idx), 64'(dpIf.op_ready), 64'd1);
    model[v.ra] = v.expVal;
    dpIf.dbg_sel = v.ra;
    #1;
    check($sformatf("row%0d_result", idx), 64'(dpIf.dbg_data), 64'(v.expVal));
    @(negedge clk);
    check($sformatf("row%0d_done_width", idx), 64'(dpIf.done), 64'd0);
    check($sformatf("row%0d_idle_bus", idx), 64'(dpIf.bus_out), 64'd0);
  endtask

  task automatic memOp(input string name, input logic isLd, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [IMM_W-1:0] imm, input int ackDelay,
                       input logic [DATA_W-1:0] rdata, input logic [DATA_W-1:0] expAddr,
                       input logic [DATA_W-1:0] expWdata);
    logic acc;
    int   n;
    int   strobeCycles;
    offerOp(isLd ? 3'd6 : 3'd7, ra, rb, 4'd2, 1'b0, imm, acc);
    if (!acc) return;
    n = 0;
    while (!(dpIf.mem_rd || dpIf.mem_wr) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, "_strobe_lat"}, 64'(n), 64'd3);
    check({name, "_addr"}, 64'(dpIf.mem_addr), 64'(expAddr));
    if (!isLd) check({name, "_wdata"}, 64'(dpIf.mem_wdata), 64'(expWdata));
    check({name, "_strobe_kind"}, {62'd0, dpIf.mem_rd, dpIf.mem_wr}, isLd ? 64'd2 : 64'd1);
    strobeCycles = 0;
    dpIf.mem_rdata = rdata;
    for (int i = 0; i < 20; i++) begin
      if (!(dpIf.mem_rd || dpIf.mem_wr)) break;
      strobeCycles++;
      check({name, "_early_done"}, 64'(dpIf.done), 64'd0);
      dpIf.mem_ack = (strobeCycles == ackDelay + 1);
      @(negedge clk);
    end
    dpIf.mem_ack = 1'b0;
    check({name, "_strobe_cycles"}, 64'(strobeCycles), 64'(ackDelay + 1));
    if (isLd) begin
      check({name, "_done_t5"}, 64'(dpIf.done), 64'd0);
      @(negedge clk);
    end
    check({name, "_done"}, 64'(dpIf.done), 64'd1);
    if (isLd) begin
      model[ra] = rdata;
      dpIf.dbg_sel = ra;
      #1;
      check({name, "_result"}, 64'(dpIf.dbg_data), 64'(rdata));
    end
    @(negedge clk);
    check({name, "_done_width"}, 64'(dpIf.done), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   nDone, nAcc, lastDone, dTotal;

    vecs[0]  = '{3'd0, 4'd1,  4'd0, 4'd0, 1'b1, 19'd5,       32'd5};
    vecs[1]  = '{3'd0, 4'd2,  4'd0, 4'd0, 1'b1, 19'd7,       32'd7};
    vecs[2]  = '{3'd0, 4'd3,  4'd1, 4'd2, 1'b0, 19'd99,      32'd12};
    vecs[3]  = '{3'd1, 4'd4,  4'd1, 4'd0, 1'b1, 19'd6,       32'hFFFF_FFFF};
    vecs[4]  = '{3'd5, 4'd5,  4'd4, 4'd0, 1'b1, 19'd36,      32'h0FFF_FFFF};
    vecs[5]  = '{3'd2, 4'd7,  4'd4, 4'd3, 1'b0, 19'd0,       32'h0000_000C};
    vecs[6]  = '{3'd3, 4'd8,  4'd3, 4'd0, 1'b1, 19'h30,      32'h0000_003C};
    vecs[7]  = '{3'd4, 4'd9,  4'd1, 4'd0, 1'b1, 19'd3,       32'h0000_0028};
    vecs[8]  = '{3'd0, 4'd11, 4'd3, 4'd0, 1'b1, 19'h7FFEC,   32'hFFFF_FFF8};
    vecs[9]  = '{3'd4, 4'd12, 4'd1, 4'd0, 1'b1, 19'd33,      32'h0000_000A};
    vecs[10] = '{3'd0, 4'd2,  4'd2, 4'd2, 1'b0, 19'd0,       32'd14};
`ifdef RTL_DP_R0_ZERO_EN
    vecs[11] = '{3'd0, 4'd0,  4'd1, 4'd0, 1'b1, 19'd9,       32'd0};
`else
    vecs[11] = '{3'd0, 4'd0,  4'd1, 4'd0, 1'b1, 19'd9,       32'd14};
`endif
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    clr             = 1'b1;
    dpIf.op_valid   = 1'b0;
    dpIf.op_code    = '0;
    dpIf.op_ra      = '0;
    dpIf.op_rb      = '0;
    dpIf.op_rc      = '0;
    dpIf.op_use_imm = 1'b0;
    dpIf.op_imm     = '0;
    dpIf.mem_rdata  = '0;
    dpIf.mem_ack    = 1'b0;
    dpIf.dbg_sel    = 4'd3;

    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(dpIf.op_ready), 64'd1);
    check("rst_done",  64'(dpIf.done), 64'd0);
    check("rst_strobes", {62'd0, dpIf.mem_rd, dpIf.mem_wr}, 64'd0);
    check("rst_bus",   64'(dpIf.bus_out), 64'd0);
    check("rst_reg3",  64'(dpIf.dbg_data), 64'd0);
    check("rst_mar",   64'(dpIf.mem_addr), 64'd0);

    for (int i = 0; i < 12; i++) runAlu(vecs[i], i);

    // stray ack while idle must not start anything
    @(negedge clk);
    dpIf.mem_rdata = 32'hDEAD_BEEF;
    dpIf.mem_ack   = 1'b1;
    @(negedge clk);
    dpIf.mem_ack = 1'b0;
    check("stray_ack_ready", 64'(dpIf.op_ready), 64'd1);
    check("stray_ack_strobes", {62'd0, dpIf.mem_rd, dpIf.mem_wr, dpIf.done}, 64'd0);

    memOp("st_r3",  1'b0, 4'd3,  4'd1, 19'h10,    3, 32'h0,         32'h15, 32'd12);
    memOp("ld_r6",  1'b1, 4'd6,  4'd1, 19'h10,    0, 32'd12,        32'h15, 32'h0);
    memOp("ld_r14", 1'b1, 4'd14, 4'd3, 19'h7FFFC, 2, 32'hA5A5_0001, 32'h8,  32'h0);

    // op_valid held high across three accepts of R13 += 1
    @(negedge clk);
    dpIf.op_code    = 3'd0;
    dpIf.op_ra      = 4'd13;
    dpIf.op_rb      = 4'd13;
    dpIf.op_rc      = 4'd0;
    dpIf.op_use_imm = 1'b1;
    dpIf.op_imm     = 19'd1;
    dpIf.op_valid   = 1'b1;
    nDone = 0;
    nAcc = 0;
    lastDone = -1;
    for (int c = 0; c < 40; c++) begin
      if (dpIf.done) begin
        if (nDone > 0) check("b2b_gap", 64'(c - lastDone), 64'd4);
        lastDone = c;
        nDone++;
      end
      if (dpIf.op_valid && dpIf.op_ready) nAcc++;
      @(negedge clk);
      if (nAcc == 3) dpIf.op_valid = 1'b0;
    end
    check("b2b_accepts", 64'(nAcc), 64'd3);
    check("b2b_dones", 64'(nDone), 64'd3);
    dpIf.dbg_sel = 4'd13;
    #1;
    check("b2b_r13", 64'(dpIf.dbg_data), 64'd3);

    // clr during the MEM wait of a load
    offerOp(3'd6, 4'd15, 4'd1, 4'd0, 1'b0, 19'h20, acc);
    for (int w = 0; w < 20 && !dpIf.mem_rd; w++) @(negedge clk);
    check("clr_pre_strobe", 64'(dpIf.mem_rd), 64'd1);
    clr = 1'b1;
    #1;
    check("clr_strobe_drop", {62'd0, dpIf.mem_rd, dpIf.mem_wr}, 64'd0);
    check("clr_ready", 64'(dpIf.op_ready), 64'd1);
    @(negedge clk);
    clr = 1'b0;
    dpIf.mem_rdata = 32'h1234_5678;
    dpIf.mem_ack   = 1'b1;
    dTotal = 0;
    for (int c = 0; c < 6; c++) begin
      if (dpIf.done) dTotal++;
      @(negedge clk);
      dpIf.mem_ack = 1'b0;
    end
    check("clr_no_done", 64'(dTotal), 64'd0);
    check("clr_ready_after", 64'(dpIf.op_ready), 64'd1);
    dpIf.dbg_sel = 4'd15;
    #1;
    check("clr_r15", 64'(dpIf.dbg_data), 64'd0);
    dpIf.dbg_sel = 4'd1;
    #1;
    check("clr_r1", 64'(dpIf.dbg_data), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
